// File: rtl/vx_tcu_fedp_sched.sv
// Issue/retire scheduler for the fused dot-product pipeline: a shadow pipe of
// in-flight ops, a per-tag FP32 accumulator file and a single-entry response register.
module vx_tcu_fedp_sched #(
  parameter int N       = 1,
  parameter int LATENCY = 32,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [2:0]          i_req_fmt_s,
  input  logic [2:0]          i_req_fmt_d,
  input  logic [TAG_W-1:0]    i_req_tag,
  input  logic                i_req_acc,
  input  logic                i_req_last,
  input  logic [N*XLEN-1:0]   i_req_a,
  input  logic [N*XLEN-1:0]   i_req_b,
  input  logic [XLEN-1:0]     i_req_c,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [TAG_W-1:0]    o_rsp_tag,
  output logic [XLEN-1:0]     o_rsp_data,
  output logic                o_fedp_enable,
  output logic [2:0]          o_fedp_fmt_s,
  output logic [2:0]          o_fedp_fmt_d,
  output logic [N*XLEN-1:0]   o_fedp_a_row,
  output logic [N*XLEN-1:0]   o_fedp_b_col,
  output logic [XLEN-1:0]     o_fedp_c_val,
  input  logic [XLEN-1:0]     i_fedp_d_val,
  output logic                o_busy
);
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int CNT_W    = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_last;
  logic [TAG_W-1:0]   r_tag [LATENCY];
  logic [CNT_W-1:0]   r_cnt [NUM_TAGS];
  logic [31:0]        r_acc [NUM_TAGS];
  logic               r_rsp_valid;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic [XLEN-1:0]    r_rsp_data;

  logic             w_tail_vld;
  logic             w_tail_last;
  logic [TAG_W-1:0] w_tail_tag;
  logic             w_stall;
  logic             w_hazard;
  logic             w_fire;
  logic             w_retire;

  assign w_tail_vld  = r_vld[LATENCY-1];
  assign w_tail_last = r_last[LATENCY-1];
  assign w_tail_tag  = r_tag[LATENCY-1];

  // Only a last op needs the response register, so only it can hold the pipe.
  assign w_stall  = w_tail_vld & w_tail_last & r_rsp_valid & ~i_rsp_ready;
  assign w_hazard = i_req_acc & (r_cnt[i_req_tag] != '0);

  assign o_req_ready   = i_reset & ~w_stall & ~w_hazard;
  assign o_fedp_enable = ~i_reset | ~w_stall;
  assign w_fire        = i_req_valid & o_req_ready;
  assign w_retire      = o_fedp_enable & w_tail_vld;
  assign o_busy        = i_reset & ((|r_vld) | r_rsp_valid);

  assign o_fedp_fmt_s = i_req_fmt_s;
  assign o_fedp_fmt_d = i_req_fmt_d;
  assign o_fedp_a_row = i_req_a;
  assign o_fedp_b_col = i_req_b;
  assign o_fedp_c_val = i_req_acc ? XLEN'(r_acc[i_req_tag]) : i_req_c;

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_tag   = r_rsp_tag;
  assign o_rsp_data  = r_rsp_data;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_vld <= '0;
    end else if (o_fedp_enable) begin
      r_vld <= {r_vld[LATENCY-2:0], w_fire};
    end
  end

  // Tag/last payload needs no reset: it is qualified by r_vld.
  always_ff @(posedge i_clk) begin
    if (o_fedp_enable) begin
      r_last   <= {r_last[LATENCY-2:0], i_req_last};
      r_tag[0] <= i_req_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        r_cnt[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if ((w_fire && i_req_tag == TAG_W'(t)) && !(w_retire && w_tail_tag == TAG_W'(t))) begin
          r_cnt[t] <= r_cnt[t] + CNT_W'(1);
        end else if (!(w_fire && i_req_tag == TAG_W'(t)) && (w_retire && w_tail_tag == TAG_W'(t))) begin
          r_cnt[t] <= r_cnt[t] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        r_acc[t] <= '0;
      end
    end else if (w_retire) begin
      r_acc[w_tail_tag] <= i_fedp_d_val[31:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
    end else if (w_retire && w_tail_last) begin
      r_rsp_valid <= 1'b1;
      r_rsp_tag   <= w_tail_tag;
      r_rsp_data  <= i_fedp_d_val;
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_tcu_fedp_sched.sv
// Bench for vx_tcu_fedp_sched: behavioural FEDP pipe, response scoreboard,
// a table of single-op vectors and hand-written multi-cycle sequences.
module tb_vx_tcu_fedp_sched;
  localparam int N = 1, LATENCY = 32, TAG_W = 4, XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_ready;
  logic [2:0]        req_fmt_s = 3'd1, req_fmt_d = 3'd1;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              req_acc = 1'b0, req_last = 1'b0;
  logic [N*XLEN-1:0] req_a = '0, req_b = '0;
  logic [XLEN-1:0]   req_c = '0;
  logic              rsp_valid, rsp_ready = 1'b1;
  logic [TAG_W-1:0]  rsp_tag;
  logic [XLEN-1:0]   rsp_data;
  logic              fedp_enable;
  logic [2:0]        fedp_fmt_s, fedp_fmt_d;
  logic [N*XLEN-1:0] fedp_a_row, fedp_b_col;
  logic [XLEN-1:0]   fedp_c_val, fedp_d_val;
  logic              busy;

  vx_tcu_fedp_sched #(.N(N), .LATENCY(LATENCY), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_fmt_s(req_fmt_s), .i_req_fmt_d(req_fmt_d), .i_req_tag(req_tag),
    .i_req_acc(req_acc), .i_req_last(req_last), .i_req_a(req_a), .i_req_b(req_b),
    .i_req_c(req_c), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_tag(rsp_tag), .o_rsp_data(rsp_data), .o_fedp_enable(fedp_enable),
    .o_fedp_fmt_s(fedp_fmt_s), .o_fedp_fmt_d(fedp_fmt_d), .o_fedp_a_row(fedp_a_row),
    .o_fedp_b_col(fedp_b_col), .o_fedp_c_val(fedp_c_val), .i_fedp_d_val(fedp_d_val),
    .o_busy(busy)
  );

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Exact conversions for normal values (enough for the vectors used here).
  function automatic real h2r(input logic [15:0] h);
    logic [63:0] d;
    if (h[14:0] == 15'd0) return 0.0;
    d = {h[15], 11'(int'(h[14:10]) - 15 + 1023), h[9:0], 42'd0};
    return $bitstoreal(d);
  endfunction

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
  endfunction

  function automatic logic [31:0] dot(input logic [N*XLEN-1:0] a, input logic [N*XLEN-1:0] b,
                                      input logic [31:0] c);
    real s;
    s = f2r(c);
    for (int i = 0; i < 2 * N; i++) s = s + h2r(a[16*i +: 16]) * h2r(b[16*i +: 16]);
    return r2f(s);
  endfunction

  // Behavioural FEDP: fixed latency, advances only when enabled.
  logic [31:0] m_pipe [LATENCY];
  always @(posedge clk) begin
    if (fedp_enable) begin
      m_pipe[0] <= dot(fedp_a_row, fedp_b_col, fedp_c_val[31:0]);
      for (int i = 1; i < LATENCY; i++) m_pipe[i] <= m_pipe[i-1];
    end
  end
  assign fedp_d_val = m_pipe[LATENCY-1];

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } rsp_t;

  rsp_t        sb[$];
  rsp_t        sb_head;
  logic [31:0] bacc [1 << TAG_W];
  logic [31:0] e_mon;
  int          rsp_cnt = 0, run = 0, last_rsp_cyc = -10;
  logic [31:0] last_data = '0;
  logic [TAG_W-1:0] last_tag = '0;

  // Inputs change only just after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      for (int t = 0; t < (1 << TAG_W); t++) bacc[t] = '0;
    end else begin
      if (req_valid && req_ready) begin
        e_mon = dot(req_a, req_b, req_acc ? bacc[req_tag] : req_c[31:0]);
        bacc[req_tag] = e_mon;
        if (req_last) sb.push_back('{req_tag, e_mon});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_spurious: got tag %0h data %0h, required no response", rsp_tag, rsp_data);
        end else begin
          sb_head = sb.pop_front();
          chk("sb_tag", 64'(rsp_tag), 64'(sb_head.tag));
          chk("sb_data", 64'(rsp_data), 64'(sb_head.data));
        end
        run = (last_rsp_cyc == cyc - 1) ? run + 1 : 1;
        last_rsp_cyc = cyc;
        last_data = rsp_data;
        last_tag = rsp_tag;
        rsp_cnt++;
      end
    end
  end

  // Called just after a posedge; returns the fire edge's cycle number and stall count.
  task automatic fire(input logic [TAG_W-1:0] tag, input logic acc, input logic last,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      output int ce, output int waited);
    int n;
    n = 0;
    req_valid = 1'b1; req_tag = tag; req_acc = acc; req_last = last;
    req_a = a; req_b = b; req_c = c;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL fire_timeout: req_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    ce = cyc;
    waited = n;
    req_valid = 1'b0; req_acc = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {62'd0, sb.size() != 0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0] a, b, c, exp;
  } vec_t;
  vec_t vt[4];

  initial begin
    int ce, ce2, w, n, base;
    vt[0] = '{4'd3,  {16'h3C00, 16'h4000}, {16'h4000, 16'h4000}, 32'h3F800000, 32'h40E00000};
    vt[1] = '{4'd12, {16'h4000, 16'h4000}, {16'h4200, 16'h3C00}, 32'h00000000, 32'h41000000};
    vt[2] = '{4'd0,  {16'h3800, 16'h0000}, {16'h4400, 16'h4400}, 32'hBF800000, 32'h3F800000};
    vt[3] = '{4'd15, {16'hBC00, 16'h3C00}, {16'h4000, 16'h4000}, 32'h40400000, 32'h40400000};

    // Reset state
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_enable", 64'(fedp_enable), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Table of single ops: latency, tag and data against hand-computed values
    foreach (vt[k]) begin
      fire(vt[k].tag, 1'b0, 1'b1, vt[k].a, vt[k].b, vt[k].c, ce, w);
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("single_lat", 64'(cyc - ce + 1), 64'(LATENCY + 1));
      chk("single_tag", 64'(rsp_tag), 64'(vt[k].tag));
      chk("single_data", 64'(rsp_data), 64'(vt[k].exp));
      wait_drain();
    end

    // Chain on tag 5: second step waits for the first to retire
    fire(4'd5, 1'b0, 1'b0, {16'h3C00, 16'h4000}, {16'h4000, 16'h4000}, 32'd0, ce, w);
    fire(4'd5, 1'b1, 1'b1, {16'h3C00, 16'h4000}, {16'h4000, 16'h4000}, 32'd0, ce2, w);
    chk("chain_wait", 64'(w), 64'(LATENCY));
    wait_drain();
    chk("chain_tag", 64'(last_tag), 64'd5);
    chk("chain_data", 64'(last_data), 64'h41400000);

    // Interleave: 16 independent tags back to back
    base = rsp_cnt;
    for (int i = 0; i < 16; i++) begin
      fire(TAG_W'(i), 1'b0, 1'b1, {16'h3C00, 16'h4000}, {16'h4000, 16'(16'h3C00 + (i << 7))},
           32'(i) << 23, ce, w);
      chk("ilv_ready", 64'(w), 64'd0);
    end
    wait_drain();
    chk("ilv_count", 64'(rsp_cnt - base), 64'd16);
    chk("ilv_consecutive", 64'(run), 64'd16);

    // Backpressure: hold rsp_ready low for 10 cycles after the first response
    base = rsp_cnt;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          fire(TAG_W'(i), 1'b0, 1'b1, {16'h4000, 16'h3C00}, {16'(16'h3C00 + (i << 8)), 16'h4000},
               32'h3F800000, ce, w);
        end
      end
      begin
        int m;
        m = 0;
        @(negedge clk);
        while (!rsp_valid && m < 200) begin
          @(negedge clk);
          m++;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("bp_enable", 64'(fedp_enable), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count", 64'(rsp_cnt - base), 64'd16);

    // Mixed: non-last op retires under a held response, the last op stalls
    rsp_ready = 1'b0;
    fire(4'd9, 1'b0, 1'b1, {16'h3C00, 16'h3C00}, {16'h3C00, 16'h3C00}, 32'd0, ce, w);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    fire(4'd7, 1'b0, 1'b0, {16'h3C00, 16'h4000}, {16'h4000, 16'h4000}, 32'h40000000, ce, w);
    fire(4'd8, 1'b0, 1'b1, {16'h4000, 16'h4000}, {16'h4000, 16'h4000}, 32'd0, ce2, w);
    wait_until(ce + LATENCY - 1);
    chk("mix_nonlast_enable", 64'(fedp_enable), 64'd1);
    wait_until(ce + LATENCY);
    chk("mix_last_stall", 64'(fedp_enable), 64'd0);
    @(posedge clk); #1;
    req_acc = 1'b1; req_tag = 4'd7;
    #1;
    chk("mix_acc7", 64'(fedp_c_val), 64'h41000000);
    repeat (3) begin
      @(negedge clk);
      chk("mix_stall_hold", 64'(fedp_enable), 64'd0);
    end
    @(posedge clk); #1;
    req_acc = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();

    // Reset with 5 ops in flight
    for (int i = 0; i < 5; i++) begin
      fire(TAG_W'(i), 1'b0, 1'b1, {16'h3C00, 16'h3C00}, {16'h4000, 16'h4000}, 32'd0, ce, w);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 1'b1; req_tag = 4'd10;
    @(negedge clk);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_enable", 64'(fedp_enable), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    req_acc = 1'b1;
    for (int t = 0; t < (1 << TAG_W); t++) begin
      req_tag = TAG_W'(t);
      #1;
      chk("flush_acc", 64'(fedp_c_val), 64'd0);
    end
    req_acc = 1'b0;
    base = rsp_cnt;
    n = 0;
    repeat (LATENCY + 10) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("flush_no_rsp", 64'(n), 64'd0);
    chk("flush_rsp_cnt", 64'(rsp_cnt - base), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
